// File: rtl/tff_bank_pkg.sv
// Shared mode encoding for the tff_bank T flip-flop bank.
package tff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE = 2'b00;
    localparam mode_t MODE_UP     = 2'b01;
    localparam mode_t MODE_DOWN   = 2'b10;
    localparam mode_t MODE_LOAD   = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with clock enable, parallel load and a per-cell reset value.
module tff_cell (
    input  logic CLK,
    input  logic RST,
    input  logic ENABLE,
    input  logic T,
    input  logic LOAD,
    input  logic D,
    input  logic RVAL,
    output logic Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (ENABLE) begin
            q_d = LOAD ? D : (q_q ^ T);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_q <= RVAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/tff_bank.sv
// WIDTH-bit bank of T flip-flops with toggle / up / down / load modes.
// Define TFF_BANK_OVF_EN to build the sticky OVF wrap flag; otherwise OVF is tied low.
module tff_bank
    import tff_bank_pkg::*;
#(
    parameter int unsigned          WIDTH       = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  mode_t            MODE,
    input  logic [WIDTH-1:0] T,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Y,
    output logic             TC,
    output logic             OVF
);

    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic             load;

    // Ripple prefix: bit i may count only when every lower bit is at its extreme.
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            ones_below[i]  = ones_below[i-1]  &  Y[i-1];
            zeros_below[i] = zeros_below[i-1] & ~Y[i-1];
        end
    end

    always_comb begin
        tog = '0;
        case (MODE)
            MODE_TOGGLE: tog = T;
            MODE_UP:     tog = ones_below;
            MODE_DOWN:   tog = zeros_below;
            default:     tog = '0;
        endcase
    end

    assign load = (MODE == MODE_LOAD);

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .CLK    (CLK),
            .RST    (RST),
            .ENABLE (ENABLE),
            .T      (tog[g]),
            .LOAD   (load),
            .D      (D[g]),
            .RVAL   (RESET_VALUE[g]),
            .Q      (Y[g])
        );
    end

    assign TC = ENABLE & (((MODE == MODE_UP)   &  (&Y)) |
                          ((MODE == MODE_DOWN) & ~(|Y)));

`ifdef TFF_BANK_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // A wrap on the same edge as CLR_OVF keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (TC) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = CLR_OVF;
    assign OVF            = 1'b0;
`endif

endmodule

// File: doc/tff_bank.md
# tff_bank

Parametrised bank of WIDTH T flip-flops sharing one clock, one asynchronous active-low reset and one enable; the successor of the single-bit T flip-flop in the lab sequential library. Beyond per-bit toggling, the bank can be switched into synchronous up-count, down-count or parallel-load mode. Count modes are built from the toggle cells themselves. It is the building block for the counters and clock dividers in the following labs.

## Interface
- WIDTH, 4, number of T flip-flops (≥1)
- RESET_VALUE, 0, WIDTH-bit value loaded into Y on reset
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- ENABLE  in  1  global clock enable; 0 = hold all state
- MODE  in  2  operation select (see Operation)
- T  in  WIDTH  per-bit toggle request (MODE_TOGGLE only)
- D  in  WIDTH  parallel load data (MODE_LOAD only)
- CLR_OVF  in  1  synchronous clear of sticky OVF
- Y  out  WIDTH  flip-flop outputs
- TC  out  1  terminal-count indicator, combinational
- OVF  out  1  sticky wrap flag (see Configuration)

## Operation
- Reset, RST=0, asynchronous, dominates everything:
  - Y = RESET_VALUE
  - OVF = 0
  - TC follows its combinational definition from the reset Y.
- ENABLE=0: Y and OVF hold, except CLR_OVF, which still clears OVF. MODE, T and D are ignored.
- With ENABLE=1, on rising CLK:
  - MODE_TOGGLE (2'b00): Y[i] <= Y[i] ^ T[i]. T=0 holds the bit.
  - MODE_UP (2'b01): bit i toggles when Y[i-1:0] are all 1; bit 0 always toggles. Equivalent to Y+1 mod 2^WIDTH.
  - MODE_DOWN (2'b10): bit i toggles when Y[i-1:0] are all 0; bit 0 always toggles. Equivalent to Y−1 mod 2^WIDTH.
  - MODE_LOAD (2'b11): Y <= D.
- Wrap-around:
  - UP from all-ones goes to 0.
  - DOWN from 0 goes to all-ones.
- TC = ENABLE & ((MODE_UP & Y==all-ones) | (MODE_DOWN & Y==0)). TC is 0 in TOGGLE and LOAD modes.
- Wrap event: a rising edge while TC=1.
- MODE may change on any cycle. The new mode takes effect at the next edge; there is no pipeline.

## Timing
- Y latency: 1 cycle from a sampled input to the new Y.
- TC is combinational from Y, MODE and ENABLE. It is valid in the same cycle, before the wrapping edge.
- OVF sets on the wrapping edge and is visible in the next cycle.
- Same edge with a wrap event and CLR_OVF=1: set wins, OVF=1.
- RST asserted mid-count: Y goes to RESET_VALUE immediately, without waiting for an edge.
- RST released: the first counting edge is the first rising CLK with RST=1.

## Configuration
- TFF_BANK_OVF_EN defined: OVF is a register.
  - Set by a wrap event.
  - Cleared by CLR_OVF=1 on a rising edge when no wrap occurs on that edge.
  - Reset to 0.
- TFF_BANK_OVF_EN undefined:
  - OVF is tied to 1'b0.
  - CLR_OVF is unused.
  - No OVF flop is synthesised.
- Y and TC are identical in both builds.

## Structure
- Package tff_bank_pkg:
  - mode localparams MODE_TOGGLE, MODE_UP, MODE_DOWN, MODE_LOAD
  - 2-bit mode_t typedef
- Sub-module tff_cell: one T flip-flop with ports CLK, RST (async active-low), ENABLE, T, LOAD, D, RVAL, Q.
  - Instantiated WIDTH times in a generate loop.
  - The bank computes each cell's toggle term from MODE, T and the lower Y bits.

## Test plan
WIDTH=4, RESET_VALUE=4'b0000 unless stated.
- Reset: RST=0 mid-operation with Y=4'b1011 → Y=4'b0000 and OVF=0 before the next edge; TC=0 with MODE_TOGGLE.
- Toggle: ENABLE=1, MODE_TOGGLE, T=4'b0101 for 2 edges from 0 → Y=4'b0101, then 4'b0000. With ENABLE=0 → Y holds.
- Up wrap: load D=4'b1110, then MODE_UP → Y=4'b1111 with TC=1; next edge Y=4'b0000 and OVF=1 (OVF_EN build); without OVF_EN, OVF stays 0.
- Down wrap: from Y=4'b0001 with MODE_DOWN → 4'b0000 with TC=1, then 4'b1111. CLR_OVF on that wrapping edge → OVF=1 (set wins); CLR_OVF on the following edge → OVF=0.
- Reset value: RESET_VALUE=4'b1010, RST pulse → Y=4'b1010; MODE_UP for 6 edges → 4'b0000 and OVF=1.
- Mode switch: MODE_UP for 3 edges from 0 → Y=3; switch to MODE_DOWN → Y=2 after 1 edge.
